// File: rtl/fc_class_select.sv
// Final-layer class selector: streams N_CLASS signed scores and reports the
// index and value of the largest one (ties resolve to the lower index).
module fc_class_select #(
  parameter int N_CLASS = 10,
  parameter int SW      = 38
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 score_valid,
  input  logic signed [SW-1:0] score,
  output logic                 score_ready,
  output logic [3:0]           class_id,
  output logic signed [SW-1:0] max_score,
  output logic                 class_valid,
  output logic                 busy,
  output logic [1:0]           dbg_state_o
);

  // Handshake: a score transfers on a rising edge where score_valid and
  // score_ready are both high; score_ready is high only while collecting,
  // and a concurrent start takes priority and drops that score.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_e;

  localparam logic signed [SW-1:0] MOST_NEG = {1'b1, {(SW-1){1'b0}}};
  localparam logic [4:0]           LAST_IDX = 5'(N_CLASS - 1);

  state_e              state_q, state_d;
  logic [4:0]          count_q, count_d;
  logic signed [SW-1:0] best_q, best_d;
  logic [3:0]          best_idx_q, best_idx_d;
  logic [3:0]          class_id_q, class_id_d;
  logic signed [SW-1:0] max_score_q, max_score_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      best_q      <= MOST_NEG;
      best_idx_q  <= '0;
      class_id_q  <= '0;
      max_score_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_id_q  <= class_id_d;
      max_score_q <= max_score_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_id_d  = class_id_q;
    max_score_d = max_score_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COLLECT;
          count_d    = '0;
          best_d     = MOST_NEG;
          best_idx_d = '0;
        end
      end
      COLLECT: begin
        if (start) begin
          count_d    = '0;
          best_d     = MOST_NEG;
          best_idx_d = '0;
        end else if (score_valid) begin
          // The first score always wins so that a score equal to MOST_NEG
          // still lands at index 0.
          if (count_q == '0 || score > best_q) begin
            best_d     = score;
            best_idx_d = count_q[3:0];
          end
          count_d = count_q + 5'd1;
          if (count_q == LAST_IDX) begin
            state_d     = REPORT;
            class_id_d  = best_idx_d;
            max_score_d = best_d;
          end
        end
      end
      REPORT: begin
        if (start) begin
          state_d    = COLLECT;
          count_d    = '0;
          best_d     = MOST_NEG;
          best_idx_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign score_ready = (state_q == COLLECT);
  assign class_valid = (state_q == REPORT);
  assign busy        = (state_q != IDLE);
  assign class_id    = class_id_q;
  assign max_score   = max_score_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fc_class_select.sv
// Bench for fc_class_select: directed scenarios plus random classifications,
// compared every cycle against a queue-based argmax model.
module tb_fc_class_select;

  localparam int N  = 10;
  localparam int SW = 38;
  localparam int W  = SW + 4;
  localparam logic signed [SW-1:0] MOST_NEG = {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [SW-1:0] MOST_POS = {1'b0, {(SW-1){1'b1}}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic                 score_valid = 1'b0;
  logic signed [SW-1:0] score = '0;
  logic                 score_ready;
  logic [3:0]           class_id;
  logic signed [SW-1:0] max_score;
  logic                 class_valid;
  logic                 busy;
  logic [1:0]           dbg_state;

  fc_class_select #(.N_CLASS(N), .SW(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .score_valid (score_valid),
    .score       (score),
    .score_ready (score_ready),
    .class_id    (class_id),
    .max_score   (max_score),
    .class_valid (class_valid),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic signed [SW-1:0] acc_q[$];
  bit                   m_collect;
  bit                   m_report;
  logic [3:0]           m_id;
  logic signed [SW-1:0] m_max;
  logic [W-1:0]         exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_collect = 0;
      m_report  = 0;
      m_id      = '0;
      m_max     = '0;
      acc_q.delete();
    end else begin
      m_report = 0;
      if (start) begin
        m_collect = 1;
        acc_q.delete();
      end else if (m_collect && score_valid) begin
        acc_q.push_back(score);
        if (acc_q.size() == N) begin
          for (int i = 0; i < N; i++)
            if (i == 0 || acc_q[i] > m_max) begin
              m_max = acc_q[i];
              m_id  = 4'(i);
            end
          exp_q.push_back({m_id, m_max});
          m_collect = 0;
          m_report  = 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [W-1:0] exp_res;
  always @(negedge clk) begin
    chk("score_ready", 64'(score_ready), 64'(m_collect));
    chk("busy",        64'(busy),        64'(m_collect | m_report));
    chk("class_valid", 64'(class_valid), 64'(m_report));
    chk("class_id",    64'(class_id),    64'(m_id));
    chk("max_score",   64'(max_score),   64'(m_max));
    if (class_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_class_valid", 64'(1), 64'(0));
      end else begin
        exp_res = exp_q.pop_front();
        chk("scoreboard_result", 64'({class_id, max_score}), 64'(exp_res));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit st, input bit v, input logic signed [SW-1:0] s);
    @(posedge clk);
    #2;
    start       = st;
    score_valid = v;
    score       = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0);
  endtask

  // Waits for class_valid; returns cycles waited, or -1 on timeout.
  task automatic wait_report(input string name, input int id,
                             input logic signed [SW-1:0] mx, output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (class_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk({name, "_timeout"}, 64'(0), 64'(1));
    else begin
      chk({name, "_class_id"},  64'(class_id),  64'(id));
      chk({name, "_max_score"}, 64'(max_score), 64'(mx));
    end
  endtask

  function automatic logic signed [SW-1:0] rnd_score();
    case ($urandom_range(0, 5))
      0: return SW'({$urandom(), $urandom()});
      1: return MOST_NEG;
      2: return MOST_POS;
      default: return SW'($signed($urandom_range(0, 40)) - 20);
    endcase
  endfunction

  int lat;
  int tbl[10];
  int n;
  bit st, v;

  initial begin
    idle(2);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_class_id", 64'(class_id), 64'(0));
    chk("reset_max_score", 64'(max_score), 64'(0));
    chk("reset_idle", 64'({score_ready, busy, class_valid}), 64'(0));

    // Back-to-back scores, tie at 90 keeps index 2
    tbl = '{5, -3, 90, 12, 90, 0, -7, 1, 2, 3};
    drive(1, 0, '0);
    for (int i = 0; i < N; i++) drive(0, 1, SW'(tbl[i]));
    drive(0, 0, '0);
    wait_report("tie", 2, SW'(90), lat);
    chk("tie_latency", 64'(lat), 64'(0));
    idle(2);

    // All scores at the most negative value
    drive(1, 0, '0);
    for (int i = 0; i < N; i++) drive(0, 1, MOST_NEG);
    drive(0, 0, '0);
    wait_report("most_neg", 0, MOST_NEG, lat);
    idle(2);

    // Ascending negatives with gaps
    drive(1, 0, '0);
    for (int i = 0; i < N; i++) begin
      drive(0, 1, SW'(i - 10));
      drive(0, 0, '0);
    end
    wait_report("gaps", 9, SW'(-1), lat);
    idle(2);

    // Abort after 4 scores, restart with max 7 at index 6
    drive(1, 0, '0);
    for (int i = 0; i < 4; i++) drive(0, 1, SW'(50 + i));
    drive(1, 1, SW'(99));
    for (int i = 0; i < N; i++) drive(0, 1, (i == 6) ? SW'(7) : SW'(i - 5));
    drive(0, 0, '0);
    wait_report("abort", 6, SW'(7), lat);
    idle(2);

    // Start during REPORT goes straight back to collecting
    drive(1, 0, '0);
    for (int i = 0; i < N; i++) drive(0, 1, SW'(i));
    drive(1, 0, '0);
    for (int i = 0; i < N; i++) drive(0, 1, SW'(20 - i));
    drive(0, 0, '0);
    wait_report("restart_in_report", 0, SW'(20), lat);
    idle(2);

    // Reset mid-collect
    drive(1, 0, '0);
    for (int i = 0; i < 6; i++) drive(0, 1, SW'(30 + i));
    @(posedge clk); #3;
    score_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        64'({class_id, max_score, score_ready, busy, class_valid}), 64'(0));
    @(posedge clk); #3 rst_n = 1'b1;
    idle(4);

    // IDLE score pulse ignored, max 100 at last index
    drive(0, 1, SW'(500));
    drive(0, 0, '0);
    drive(1, 0, '0);
    for (int i = 0; i < N; i++) drive(0, 1, (i == 9) ? SW'(100) : SW'(i * 3));
    drive(0, 0, '0);
    wait_report("idle_pulse", 9, SW'(100), lat);
    idle(2);

    // Random classifications with gaps, aborts and stray valids
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0) drive(0, 1, rnd_score());
      drive(1, $urandom_range(0, 1) == 1, rnd_score());
      n = 0;
      for (int c = 0; c < 200 && n < N; c++) begin
        st = ($urandom_range(0, 39) == 0);
        v  = ($urandom_range(0, 9) < 7);
        drive(st, v, rnd_score());
        if (st) n = 0;
        else if (v) n++;
      end
      if ($urandom_range(0, 3) == 0) drive(1, 0, '0);
      else drive(0, $urandom_range(0, 1) == 1, rnd_score());
      idle($urandom_range(0, 3));
    end
    drive(0, 0, '0);
    // Close any classification left open by a final start
    if (m_collect) begin
      for (int i = 0; i < N; i++) drive(0, 1, rnd_score());
    end
    idle(4);

    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fc_class_select.md
FC_CLASS_SELECT -- requirements
Module: fc_class_select

Interface
REQ-001 Parameter N_CLASS, default 10: number of class scores per image, range 2..16.
REQ-002 Parameter SW, default 38: score width, signed two's complement, matching the fully-connected neuron output width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that opens a new classification.
REQ-006 score_valid  input  1  a score is presented this cycle.
REQ-007 score  input  SW  signed neuron result for the next class, in class order 0..N_CLASS-1.
REQ-008 score_ready  output  1  block accepts a score this cycle.
REQ-009 class_id  output  4  index of the winning class.
REQ-010 max_score  output  SW  signed score of the winning class.
REQ-011 class_valid  output  1  one-cycle pulse: class_id and max_score are final.
REQ-012 busy  output  1  classification in progress.

Function
REQ-013 FSM states: IDLE, COLLECT, REPORT; encoding is free.
REQ-014 IDLE: score_ready=0, busy=0; start -> COLLECT.
REQ-015 Entry to COLLECT: clear the count to 0, load best score with the most negative SW-bit value, load best index with 0.
REQ-016 COLLECT: score_ready=1 and busy=1; a score is accepted on a cycle with score_valid=1 and score_ready=1.
REQ-017 On accept: compare signed; if score > best score (strictly), best score <= score and best index <= count; count increments.
REQ-018 Ties keep the lower index; the first accepted score always replaces the initial value, including a score equal to the most negative value.
REQ-019 The accept that brings the count to N_CLASS moves the FSM to REPORT on the same edge, with that score already included in the comparison.
REQ-020 REPORT lasts exactly one cycle: class_valid=1, busy=1, score_ready=0; then IDLE.
REQ-021 Latency: class_valid is high in the cycle after the clock edge that accepts the last score.
REQ-022 class_id and max_score update only on the REPORT-entry edge; they hold through IDLE and the next COLLECT until the next REPORT.
REQ-023 score_valid while in IDLE or REPORT is ignored: no count or best-score change.
REQ-024 start during COLLECT aborts and restarts: count and best values are re-initialised, and a score_valid in the same cycle is dropped.
REQ-025 start during REPORT: class_valid still pulses this cycle, and the FSM goes to COLLECT instead of IDLE.
REQ-026 Gaps in score_valid during COLLECT stall the count without a timeout.
REQ-027 Count width is 5 bits; the count never exceeds N_CLASS.

Reset
REQ-028 While rst_n=0: state=IDLE, count=0, class_id=0, max_score=0, class_valid=0, score_ready=0, busy=0.
REQ-029 Assertion of rst_n takes effect immediately without a clock edge; release is synchronised to the design by the system.
REQ-030 Reset mid-COLLECT discards partial results; no class_valid pulse follows the reset.

Verification
REQ-031 start; scores 5,-3,90,12,90,0,-7,1,2,3 back-to-back -> class_valid one cycle after the 10th accept; class_id=2, max_score=90 (tie kept at lower index).
REQ-032 start; all ten scores equal to -2^37 -> class_id=0, max_score=-2^37.
REQ-033 start; scores -10,-9,...,-1 with score_valid low on alternate cycles -> class_id=9, max_score=-1; there is no early class_valid.
REQ-034 start; 4 scores; start again; 10 scores with the maximum 7 at index 6 -> exactly one class_valid pulse, class_id=6, max_score=7.
REQ-035 start; 6 scores; rst_n low for 1 cycle mid-clock -> outputs are 0 immediately, there is no class_valid, and score_ready=0 until the next start.
REQ-036 A score_valid pulse in IDLE, followed by start and 10 scores where the maximum 100 is at index 9 -> class_id=9, max_score=100; the IDLE pulse has no effect.
